// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetches 16/48-bit instructions from RAM and hands them to decode over valid/ready
module instr_fetch_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd_en,
  input  logic [47:0]           mem_data_in,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [47:0]           instr_data,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_is_long,
  output logic                  misalign_err
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_HOLD} state_t;
  state_t state, state_nxt;
  logic [ADDR_WIDTH-1:0] pc;
  logic [15:0] hw;
  logic is_long;
  assign mem_addr = pc;
  assign hw       = mem_data_in[47:32];
  assign is_long  = hw[15];
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  // next state: a redirect always restarts fetch from the request phase
  always_comb
    state_nxt = redirect_valid     ? S_REQ  :
                state == S_IDLE    ? S_REQ  :
                state == S_REQ     ? S_RESP :
                state == S_RESP    ? S_HOLD :
                instr_ready        ? S_RESP : S_HOLD;
  // read issue: on the request phase, or back-to-back when decode takes the held instruction
  always_comb
    mem_rd_en = !redirect_valid && (state == S_REQ || (state == S_HOLD && instr_ready));
  // pc, presented instruction and sticky misalignment flag
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc            <= RESET_PC;
      instr_valid   <= 1'b0;
      instr_data    <= '0;
      instr_pc      <= '0;
      instr_is_long <= 1'b0;
      misalign_err  <= 1'b0;
    end else if (redirect_valid) begin
      pc           <= {redirect_pc[ADDR_WIDTH-1:1], 1'b0};
      instr_valid  <= 1'b0;
      misalign_err <= misalign_err | redirect_pc[0];
    end else if (state == S_RESP) begin
      instr_data    <= is_long ? mem_data_in : {hw, 32'h0};
      instr_pc      <= pc;
      instr_is_long <= is_long;
      instr_valid   <= 1'b1;
      pc            <= pc + ADDR_WIDTH'(is_long ? 6 : 2);
    end else if (state == S_HOLD && instr_ready) begin
      instr_valid <= 1'b0;
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: scoreboard bench for the instruction fetch unit
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] mem_addr, instr_pc, w_addr, w_pc;
  logic        mem_rd_en, instr_valid, instr_is_long, misalign_err;
  logic        w_rd_en, w_valid, w_long, w_mis;
  logic [47:0] mem_data_in = '0, instr_data, w_data_in = '0, w_data;
  logic        redirect_valid = 1'b0, instr_ready = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [7:0]  mem [0:511];
  int checks = 0, failures = 0;

  typedef struct {logic [31:0] pc; logic [47:0] data; logic lng;} exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
    .mem_data_in(mem_data_in), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
    .instr_pc(instr_pc), .instr_is_long(instr_is_long), .misalign_err(misalign_err)
  );

  instr_fetch_unit #(.ADDR_WIDTH(32), .RESET_PC(32'hFFFF_FFFE)) u_w (
    .clk(clk), .rst_n(rst_n), .mem_addr(w_addr), .mem_rd_en(w_rd_en),
    .mem_data_in(w_data_in), .redirect_valid(1'b0), .redirect_pc(32'h0),
    .instr_valid(w_valid), .instr_ready(1'b0), .instr_data(w_data),
    .instr_pc(w_pc), .instr_is_long(w_long), .misalign_err(w_mis)
  );

  function automatic logic [47:0] rd6(input logic [31:0] a);
    logic [47:0] d = '0;
    logic [8:0] idx;
    for (int i = 0; i < 6; i++) begin
      idx = a[8:0] + 9'(i);
      d = {d[39:0], mem[idx]};
    end
    return d;
  endfunction

  always @(posedge clk) begin
    if (mem_rd_en) mem_data_in <= rd6(mem_addr);
    if (w_rd_en)   w_data_in   <= rd6(w_addr);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push_seq(input logic [31:0] start, input int n);
    logic [31:0] pc = start;
    logic [47:0] d;
    exp_t e;
    for (int k = 0; k < n; k++) begin
      d = rd6(pc);
      e.pc = pc;
      e.lng = d[47];
      e.data = d[47] ? d : {d[47:32], 32'h0};
      sb.push_back(e);
      pc = pc + (d[47] ? 32'd6 : 32'd2);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    redirect_valid = 1'b0;
    rst_n = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input int bound);
    int n = 0;
    while (!instr_valid && n < bound) begin
      tick;
      n++;
    end
    check("wait_valid", {63'h0, instr_valid}, 64'h1);
  endtask

  // accepted instructions are compared against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && instr_valid && instr_ready) begin
      if (sb.size() == 0) check("sb_underflow", 64'h1, 64'h0);
      else begin
        e = sb.pop_front();
        check("sb_pc", {32'h0, instr_pc}, {32'h0, e.pc});
        check("sb_data", {16'h0, instr_data}, {16'h0, e.data});
        check("sb_long", {63'h0, instr_is_long}, {63'h0, e.lng});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'(i) ^ 8'h3C;
    mem[0] = 8'h00; mem[1] = 8'h12; mem[2] = 8'h80; mem[3] = 8'h34;
    mem[4] = 8'hDE; mem[5] = 8'hAD; mem[6] = 8'hBE; mem[7] = 8'hEF;
    mem[9'h1FE] = 8'hA5; mem[9'h1FF] = 8'h5A;
    // reset state and steady streaming with ready held high
    instr_ready = 1'b1;
    tick;
    tick;
    check("rst_valid", {63'h0, instr_valid}, 64'h0);
    check("rst_rd_en", {63'h0, mem_rd_en}, 64'h0);
    check("rst_mis", {63'h0, misalign_err}, 64'h0);
    check("rst_data", {16'h0, instr_data}, 64'h0);
    check("rst_pc", {32'h0, instr_pc}, 64'h0);
    check("rst_long", {63'h0, instr_is_long}, 64'h0);
    check("rst_addr", {32'h0, mem_addr}, 64'h0);
    push_seq(32'h0, 9);
    rst_n = 1'b1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      tick;
      check("valid_pat", {63'h0, instr_valid}, {63'h0, (cyc >= 3 && (cyc - 3) % 2 == 0)});
      if (cyc == 1) begin
        check("first_rd_en", {63'h0, mem_rd_en}, 64'h1);
        check("first_addr", {32'h0, mem_addr}, 64'h0);
      end
      if (cyc == 3) begin
        check("i0_pc", {32'h0, instr_pc}, 64'h0);
        check("i0_data", {16'h0, instr_data}, 64'h0012_0000_0000);
        check("i0_long", {63'h0, instr_is_long}, 64'h0);
      end
      if (cyc == 5) begin
        check("i1_pc", {32'h0, instr_pc}, 64'h2);
        check("i1_data", {16'h0, instr_data}, 64'h8034_DEAD_BEEF);
        check("i1_long", {63'h0, instr_is_long}, 64'h1);
        check("i1_next_addr", {32'h0, mem_addr}, 64'h8);
      end
    end
    instr_ready = 1'b0;
    check("a_sb_empty", 64'(sb.size()), 64'h0);
    // wrap-around instance: long instruction at the top of the address space
    check("w_valid", {63'h0, w_valid}, 64'h1);
    check("w_pc", {32'h0, w_pc}, 64'hFFFF_FFFE);
    check("w_data", {16'h0, w_data}, 64'hA55A_0012_8034);
    check("w_long", {63'h0, w_long}, 64'h1);
    check("w_next_addr", {32'h0, w_addr}, 64'h4);
    // back-pressure
    push_seq(32'h0, 2);
    do_reset;
    tick;
    tick;
    tick;
    check("bp_valid", {63'h0, instr_valid}, 64'h1);
    for (int k = 0; k < 5; k++) begin
      tick;
      check("bp_hold_valid", {63'h0, instr_valid}, 64'h1);
      check("bp_hold_pc", {32'h0, instr_pc}, 64'h0);
      check("bp_hold_data", {16'h0, instr_data}, 64'h0012_0000_0000);
      check("bp_rd_en", {63'h0, mem_rd_en}, 64'h0);
      check("bp_addr", {32'h0, mem_addr}, 64'h2);
    end
    instr_ready = 1'b1;
    #1;
    check("bp_go_rd_en", {63'h0, mem_rd_en}, 64'h1);
    check("bp_go_addr", {32'h0, mem_addr}, 64'h2);
    tick;
    check("bp_resp_valid", {63'h0, instr_valid}, 64'h0);
    tick;
    check("bp_i1_pc", {32'h0, instr_pc}, 64'h2);
    tick;
    instr_ready = 1'b0;
    tick;
    check("b_sb_empty", 64'(sb.size()), 64'h0);
    // redirect while the response is in flight
    instr_ready = 1'b1;
    push_seq(32'h100, 2);
    do_reset;
    tick;
    tick;
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    #1;
    check("rd_rd_en_blocked", {63'h0, mem_rd_en}, 64'h0);
    tick;
    redirect_valid = 1'b0;
    #1;
    check("rd_valid", {63'h0, instr_valid}, 64'h0);
    check("rd_rd_en", {63'h0, mem_rd_en}, 64'h1);
    check("rd_addr", {32'h0, mem_addr}, 64'h100);
    tick;
    check("rd_drop", {63'h0, instr_valid}, 64'h0);
    tick;
    check("rd_pc", {32'h0, instr_pc}, 64'h100);
    tick;
    tick;
    tick;
    instr_ready = 1'b0;
    wait_valid(4);
    check("c_sb_empty", 64'(sb.size()), 64'h0);
    check("c_mis", {63'h0, misalign_err}, 64'h0);
    // odd redirect target
    push_seq(32'h100, 1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h101;
    tick;
    redirect_valid = 1'b0;
    #1;
    check("mis_set", {63'h0, misalign_err}, 64'h1);
    check("mis_valid", {63'h0, instr_valid}, 64'h0);
    check("mis_rd_en", {63'h0, mem_rd_en}, 64'h1);
    check("mis_addr", {32'h0, mem_addr}, 64'h100);
    instr_ready = 1'b1;
    tick;
    tick;
    tick;
    instr_ready = 1'b0;
    repeat (4) tick;
    check("mis_sticky", {63'h0, misalign_err}, 64'h1);
    check("d_sb_empty", 64'(sb.size()), 64'h0);
    check("d_hold_valid", {63'h0, instr_valid}, 64'h1);
    // asynchronous reset while holding an instruction
    rst_n = 1'b0;
    #1;
    check("ar_valid", {63'h0, instr_valid}, 64'h0);
    check("ar_mis", {63'h0, misalign_err}, 64'h0);
    check("ar_addr", {32'h0, mem_addr}, 64'h0);
    check("ar_rd_en", {63'h0, mem_rd_en}, 64'h0);
    tick;
    rst_n = 1'b1;
    tick;
    check("ar_refetch_rd_en", {63'h0, mem_rd_en}, 64'h1);
    check("ar_refetch_addr", {32'h0, mem_addr}, 64'h0);
    check("ar_v1", {63'h0, instr_valid}, 64'h0);
    tick;
    check("ar_v2", {63'h0, instr_valid}, 64'h0);
    tick;
    check("ar_v3", {63'h0, instr_valid}, 64'h1);
    check("ar_pc", {32'h0, instr_pc}, 64'h0);
    check("e_sb_empty", 64'(sb.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
